fsm_prog: RTL and testbench

FSM_PROG -- requirements
Module: fsm_prog

---
 rtl/fsm_prog.sv | 167 ++++++++++++++++
 tb/tb_fsm_prog.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_prog.sv
`default_nettype none
// ============================================================================
// Module   : fsm_prog
// Purpose  : Table-programmed state machine with per-state priority-resolved
//            input transitions and a per-state dwell timeout.
// Revision : 1.0
// ============================================================================
module fsm_prog #(
  parameter int STATES      = 16,
  parameter int INPUTS      = 8,
  parameter int PRIO_W      = 4,
  parameter int TMO_W       = 16,
  parameter int RESET_STATE = 0,
  localparam int SW = (STATES > 1) ? $clog2(STATES) : 1,
  localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [INPUTS-1:0] in,
  input  logic              cfg_we,
  input  logic [SW-1:0]     cfg_state,
  input  logic [IW-1:0]     cfg_input,
  input  logic              cfg_en,
  input  logic [PRIO_W-1:0] cfg_prio,
  input  logic [SW-1:0]     cfg_next,
  input  logic              tmo_we,
  input  logic [SW-1:0]     tmo_state,
  input  logic [TMO_W-1:0]  tmo_val,
  input  logic [SW-1:0]     tmo_next,
  output logic              cfg_err,
  output logic [SW-1:0]     state,
  output logic              trans,
  output logic              trans_tmo,
  output logic [IW-1:0]     trans_idx,
  output logic [TMO_W-1:0]  dwell
);

  logic              en_q       [STATES][INPUTS];
  logic              en_d       [STATES][INPUTS];
  logic [PRIO_W-1:0] prio_q     [STATES][INPUTS];
  logic [PRIO_W-1:0] prio_d     [STATES][INPUTS];
  logic [SW-1:0]     next_q     [STATES][INPUTS];
  logic [SW-1:0]     next_d     [STATES][INPUTS];
  logic [TMO_W-1:0]  tmo_val_q  [STATES];
  logic [TMO_W-1:0]  tmo_val_d  [STATES];
  logic [SW-1:0]     tmo_next_q [STATES];
  logic [SW-1:0]     tmo_next_d [STATES];

  logic [SW-1:0]    state_q, state_d;
  logic [TMO_W-1:0] dwell_q, dwell_d;
  logic [IW-1:0]    trans_idx_q, trans_idx_d;
  logic             trans_q, trans_d;
  logic             trans_tmo_q, trans_tmo_d;
  logic             cfg_err_q, cfg_err_d;

  logic              w_win_vld;
  logic [IW-1:0]     w_win_idx;
  logic [PRIO_W-1:0] w_win_prio;
  logic              w_tmo_hit;
  logic              w_cfg_ok;
  logic              w_tmo_ok;

  // Strict '>' keeps the earliest index on equal priority.
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_idx  = '0;
    w_win_prio = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (run && in[i] && en_q[state_q][i] &&
          (!w_win_vld || (prio_q[state_q][i] > w_win_prio))) begin
        w_win_vld  = 1'b1;
        w_win_idx  = IW'(i);
        w_win_prio = prio_q[state_q][i];
      end
    end
  end

  assign w_tmo_hit = run && (tmo_val_q[state_q] != '0) &&
                     (dwell_q == (tmo_val_q[state_q] - TMO_W'(1)));

  assign w_cfg_ok = (32'(cfg_state) < STATES) && (32'(cfg_next) < STATES) &&
                    (32'(cfg_input) < INPUTS);
  assign w_tmo_ok = (32'(tmo_state) < STATES) && (32'(tmo_next) < STATES);

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    trans_d     = 1'b0;
    trans_tmo_d = 1'b0;
    trans_idx_d = trans_idx_q;
    if (w_win_vld) begin
      state_d     = next_q[state_q][w_win_idx];
      dwell_d     = '0;
      trans_d     = 1'b1;
      trans_idx_d = w_win_idx;
    end else if (w_tmo_hit) begin
      state_d     = tmo_next_q[state_q];
      dwell_d     = '0;
      trans_d     = 1'b1;
      trans_tmo_d = 1'b1;
    end else if (run && (dwell_q != '1)) begin
      dwell_d = dwell_q + TMO_W'(1);
    end
  end

  // Table updates land after evaluation, so a write is seen one cycle later.
  always_comb begin
    en_d       = en_q;
    prio_d     = prio_q;
    next_d     = next_q;
    tmo_val_d  = tmo_val_q;
    tmo_next_d = tmo_next_q;
    if (cfg_we && w_cfg_ok) begin
      en_d[cfg_state][cfg_input]   = cfg_en;
      prio_d[cfg_state][cfg_input] = cfg_prio;
      next_d[cfg_state][cfg_input] = cfg_next;
    end
    if (tmo_we && w_tmo_ok) begin
      tmo_val_d[tmo_state]  = tmo_val;
      tmo_next_d[tmo_state] = tmo_next;
    end
  end

  assign cfg_err_d = (cfg_we && !w_cfg_ok) || (tmo_we && !w_tmo_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SW'(RESET_STATE);
      dwell_q     <= '0;
      trans_q     <= 1'b0;
      trans_tmo_q <= 1'b0;
      trans_idx_q <= '0;
      cfg_err_q   <= 1'b0;
      for (int s = 0; s < STATES; s++) begin
        tmo_val_q[s]  <= '0;
        tmo_next_q[s] <= '0;
        for (int i = 0; i < INPUTS; i++) begin
          en_q[s][i]   <= 1'b0;
          prio_q[s][i] <= '0;
          next_q[s][i] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      trans_q     <= trans_d;
      trans_tmo_q <= trans_tmo_d;
      trans_idx_q <= trans_idx_d;
      cfg_err_q   <= cfg_err_d;
      en_q        <= en_d;
      prio_q      <= prio_d;
      next_q      <= next_d;
      tmo_val_q   <= tmo_val_d;
      tmo_next_q  <= tmo_next_d;
    end
  end

  assign state     = state_q;
  assign dwell     = dwell_q;
  assign trans     = trans_q;
  assign trans_tmo = trans_tmo_q;
  assign trans_idx = trans_idx_q;
  assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_prog
// Purpose  : Directed and randomized checks of fsm_prog against a table model.
// Revision : 1.0
// ============================================================================
module tb_fsm_prog;
  localparam int ST = 12;
  localparam int NI = 8;
  localparam int PW = 4;
  localparam int TW = 8;
  localparam int RS = 0;
  localparam int SW = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [NI-1:0] in_v = '0;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_state = '0;
  logic [IW-1:0] cfg_input = '0;
  logic          cfg_en = 1'b0;
  logic [PW-1:0] cfg_prio = '0;
  logic [SW-1:0] cfg_next = '0;
  logic          tmo_we = 1'b0;
  logic [SW-1:0] tmo_state = '0;
  logic [TW-1:0] tmo_val = '0;
  logic [SW-1:0] tmo_next = '0;
  logic          cfg_err, trans, trans_tmo;
  logic [SW-1:0] state;
  logic [IW-1:0] trans_idx;
  logic [TW-1:0] dwell;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  fsm_prog #(.STATES(ST), .INPUTS(NI), .PRIO_W(PW), .TMO_W(TW), .RESET_STATE(RS)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .in(in_v),
    .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_input(cfg_input),
    .cfg_en(cfg_en), .cfg_prio(cfg_prio), .cfg_next(cfg_next),
    .tmo_we(tmo_we), .tmo_state(tmo_state), .tmo_val(tmo_val), .tmo_next(tmo_next),
    .cfg_err(cfg_err), .state(state), .trans(trans), .trans_tmo(trans_tmo),
    .trans_idx(trans_idx), .dwell(dwell)
  );

  always #5 clk = ~clk;

  // Reference model: table contents and observable outputs as plain integers.
  int m_en [ST][NI];
  int m_prio [ST][NI];
  int m_next [ST][NI];
  int m_tv [ST];
  int m_tn [ST];
  int m_state, m_dwell, m_trans, m_tmo, m_idx, m_err;

  always @(posedge clk) begin : p_model
    int st, best, win;
    if (!rst_n) begin
      m_state = RS; m_dwell = 0; m_trans = 0; m_tmo = 0; m_idx = 0; m_err = 0;
      for (int s = 0; s < ST; s++) begin
        m_tv[s] = 0; m_tn[s] = 0;
        for (int i = 0; i < NI; i++) begin
          m_en[s][i] = 0; m_prio[s][i] = 0; m_next[s][i] = 0;
        end
      end
    end else begin
      st = m_state; best = -1; win = -1;
      if (run) begin
        for (int i = 0; i < NI; i++)
          if (in_v[i] && m_en[st][i] != 0 && m_prio[st][i] > best) best = m_prio[st][i];
        for (int i = NI - 1; i >= 0; i--)
          if (in_v[i] && m_en[st][i] != 0 && m_prio[st][i] == best) win = i;
      end
      if (win >= 0) begin
        m_state = m_next[st][win]; m_trans = 1; m_tmo = 0; m_idx = win; m_dwell = 0;
      end else if (run && m_tv[st] != 0 && m_dwell == m_tv[st] - 1) begin
        m_state = m_tn[st]; m_trans = 1; m_tmo = 1; m_dwell = 0;
      end else begin
        m_trans = 0; m_tmo = 0;
        if (run && m_dwell < (1 << TW) - 1) m_dwell = m_dwell + 1;
      end
      m_err = 0;
      if (cfg_we) begin
        if (int'(cfg_state) < ST && int'(cfg_next) < ST && int'(cfg_input) < NI) begin
          m_en[cfg_state][cfg_input]   = int'(cfg_en);
          m_prio[cfg_state][cfg_input] = int'(cfg_prio);
          m_next[cfg_state][cfg_input] = int'(cfg_next);
        end else m_err = 1;
      end
      if (tmo_we) begin
        if (int'(tmo_state) < ST && int'(tmo_next) < ST) begin
          m_tv[tmo_state] = int'(tmo_val);
          m_tn[tmo_state] = int'(tmo_next);
        end else m_err = 1;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("m.state", 32'(state), m_state);
      cmp("m.dwell", 32'(dwell), m_dwell);
      cmp("m.trans", 32'(trans), m_trans);
      cmp("m.trans_tmo", 32'(trans_tmo), m_tmo);
      cmp("m.trans_idx", 32'(trans_idx), m_idx);
      cmp("m.cfg_err", 32'(cfg_err), m_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ent(input int s, input int i, input int e, input int p, input int n);
    cfg_we = 1'b1; cfg_state = SW'(s); cfg_input = IW'(i);
    cfg_en = e[0]; cfg_prio = PW'(p); cfg_next = SW'(n);
  endtask

  task automatic wr_ent(input int s, input int i, input int e, input int p, input int n);
    set_ent(s, i, e, p, n);
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic set_tmo(input int s, input int v, input int n);
    tmo_we = 1'b1; tmo_state = SW'(s); tmo_val = TW'(v); tmo_next = SW'(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with a write attempt that must be ignored
    set_ent(0, 0, 1, 1, 5);
    tick(1);
    cfg_we = 1'b0;
    chk_on = 1'b1;
    cmp("rst.state", 32'(state), 0);
    cmp("rst.dwell", 32'(dwell), 0);
    cmp("rst.trans", 32'(trans), 0);
    cmp("rst.idx", 32'(trans_idx), 0);
    cmp("rst.err", 32'(cfg_err), 0);
    rst_n = 1'b1; run = 1'b1; in_v = '1;
    tick(10);
    cmp("empty.state", 32'(state), 0);
    cmp("empty.trans", 32'(trans), 0);
    cmp("empty.dwell", 32'(dwell), 10);

    // Highest priority wins
    in_v = '0;
    wr_ent(0, 2, 1, 3, 5);
    wr_ent(0, 6, 1, 7, 9);
    in_v = 8'h44;
    tick(1);
    cmp("prio.state", 32'(state), 9);
    cmp("prio.trans", 32'(trans), 1);
    cmp("prio.idx", 32'(trans_idx), 6);
    cmp("prio.dwell", 32'(dwell), 0);
    in_v = '0;
    tick(1);
    cmp("prio.pulse", 32'(trans), 0);

    // Tie goes to lowest index; priority 0 still eligible
    do_reset();
    wr_ent(0, 1, 1, 5, 2);
    wr_ent(0, 4, 1, 5, 3);
    in_v = 8'h12;
    tick(1);
    cmp("tie.state", 32'(state), 2);
    cmp("tie.idx", 32'(trans_idx), 1);
    in_v = '0;
    wr_ent(2, 7, 1, 0, 11);
    in_v = 8'h80;
    tick(1);
    cmp("p0.state", 32'(state), 11);
    cmp("p0.idx", 32'(trans_idx), 7);
    in_v = '0;

    // Timeout fires on the 4th edge after entry
    do_reset();
    set_tmo(0, 4, 7);
    tick(1);
    tmo_we = 1'b0;
    tick(2);
    cmp("tmo.pre_state", 32'(state), 0);
    cmp("tmo.pre_dwell", 32'(dwell), 3);
    tick(1);
    cmp("tmo.state", 32'(state), 7);
    cmp("tmo.trans", 32'(trans), 1);
    cmp("tmo.flag", 32'(trans_tmo), 1);

    // Input beats timeout on the same edge
    do_reset();
    set_tmo(0, 4, 7);
    set_ent(0, 3, 1, 0, 10);
    tick(1);
    tmo_we = 1'b0; cfg_we = 1'b0;
    tick(2);
    in_v = 8'h08;
    tick(1);
    cmp("tvi.state", 32'(state), 10);
    cmp("tvi.flag", 32'(trans_tmo), 0);
    cmp("tvi.idx", 32'(trans_idx), 3);
    in_v = '0;

    // Rejected writes and write/evaluate ordering
    do_reset();
    wr_ent(0, 0, 1, 1, 12);
    cmp("bad.err", 32'(cfg_err), 1);
    tick(1);
    cmp("bad.err_pulse", 32'(cfg_err), 0);
    in_v = 8'h01;
    tick(1);
    cmp("bad.unchanged", 32'(state), 0);
    in_v = '0;
    wr_ent(0, 0, 1, 1, 5);
    set_ent(0, 0, 1, 1, 8);
    in_v = 8'h01;
    tick(1);
    cfg_we = 1'b0; in_v = '0;
    cmp("old.state", 32'(state), 5);
    set_ent(5, 2, 1, 1, 6);
    set_tmo(13, 1, 0);
    tick(1);
    cfg_we = 1'b0; tmo_we = 1'b0;
    cmp("dual.err", 32'(cfg_err), 1);
    in_v = 8'h04;
    tick(1);
    cmp("dual.state", 32'(state), 6);
    in_v = '0;

    // run=0 freezes, then reset overrides a pending transition
    do_reset();
    wr_ent(0, 1, 1, 2, 4);
    tick(3);
    run = 1'b0; in_v = 8'h02;
    tick(5);
    cmp("frz.state", 32'(state), 0);
    cmp("frz.trans", 32'(trans), 0);
    cmp("frz.dwell", 32'(dwell), 4);
    run = 1'b1; rst_n = 1'b0;
    tick(1);
    cmp("rov.state", 32'(state), 0);
    cmp("rov.trans", 32'(trans), 0);
    cmp("rov.dwell", 32'(dwell), 0);
    rst_n = 1'b1;
    tick(2);
    cmp("rov.cleared", 32'(state), 0);
    cmp("rov.dwell2", 32'(dwell), 2);
    in_v = '0;

    // Dwell saturates
    do_reset();
    tick(260);
    cmp("sat.dwell", 32'(dwell), 255);

    // Randomized traffic checked every cycle against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      run       = ($urandom_range(0, 9) != 0);
      in_v      = NI'($urandom & $urandom);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_state = SW'($urandom_range(0, 12));
      cfg_input = IW'($urandom_range(0, 7));
      cfg_en    = ($urandom_range(0, 3) != 0);
      cfg_prio  = PW'($urandom);
      cfg_next  = SW'($urandom_range(0, 12));
      tmo_we    = ($urandom_range(0, 7) == 0);
      tmo_state = SW'($urandom_range(0, 12));
      tmo_val   = TW'($urandom_range(0, 6));
      tmo_next  = SW'($urandom_range(0, 12));
      tick(1);
    end
    rst_n = 1'b1; cfg_we = 1'b0; tmo_we = 1'b0;
    tick(1);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
